// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle data-memory responder for the pipeline MEM stage.
//               Word-addressed array that answers each load/store after a
//               fixed programmable latency, holding the pipeline with stall
//               until the response is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_BITS = 8,    // word-address width (must be < 32)
    parameter int DATA_W    = 32,   // data word width
    parameter int LATENCY   = 2     // BUSY cycles per access, 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] Write_data,
    output logic [DATA_W-1:0] Read_data,
    output logic              rsp_valid,
    output logic              stall,
    output logic              err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0] c_CNT_INIT  = 4'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_BUSY   = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // ------------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic                 r_is_write;   // store (also set when both strobes are high)
    logic                 r_oor;        // captured address was out of range
    logic                 r_both;       // both strobes were high on acceptance
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_rsp_valid;
    logic                 r_err;

    logic [DATA_W-1:0]    r_mem [0:c_DEPTH-1];

    logic                 w_req;
    logic                 w_addr_oor;
    logic                 w_access;

    assign w_req    = Mem_Read | Mem_Write;
    // The access happens on the edge that leaves the last BUSY cycle.
    assign w_access = (r_state == c_ST_BUSY) && (r_cnt == 4'd0);

    // Any set bit above the word index means the address is outside the array.
    if (ADDR_BITS < 32) begin : g_range_chk
        assign w_addr_oor = |Address[31:ADDR_BITS];
    end else begin : g_full_range
        assign w_addr_oor = 1'b0;
    end

    // Request sequencing: capture in IDLE, count down in BUSY, pulse in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_is_write  <= 1'b0;
            r_oor       <= 1'b0;
            r_both      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        // A write strobe wins over a simultaneous read strobe.
                        r_is_write <= Mem_Write;
                        r_both     <= Mem_Read & Mem_Write;
                        r_oor      <= w_addr_oor;
                        r_addr     <= Address[ADDR_BITS-1:0];
                        r_wdata    <= Write_data;
                        r_cnt      <= c_CNT_INIT;
                        r_state    <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= c_ST_DONE;
                        r_rsp_valid <= 1'b1;
                        // Stores leave Read_data untouched; bad loads return zero.
                        if (!r_is_write) begin
                            r_rdata <= r_oor ? '0 : r_mem[r_addr];
                        end
                        if (r_oor || r_both) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    // Always drop back to IDLE so a held request is re-accepted
                    // as a fresh access rather than answered twice.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Array write port: only completed, in-range stores reach the array, and
    // a reset in the completion cycle discards the pending store.
    always_ff @(posedge clk) begin
        if (!reset && w_access && r_is_write && !r_oor) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Stall follows the request while idle, is forced high while busy.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            c_ST_IDLE: stall = w_req;
            c_ST_BUSY: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    assign Read_data = r_rdata;
    assign rsp_valid = r_rsp_valid;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder. Three
//               instances with LATENCY 2, 1 and 15 share one clock; each has
//               its own request signals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        rd    [3];
    logic        wr    [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rdata [3];
    logic        rv    [3];
    logic        st    [3];
    logic        er    [3];

    int checks;
    int errors;

    data_mem_responder #(.ADDR_BITS(8), .DATA_W(32), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .Mem_Read(rd[0]), .Mem_Write(wr[0]),
        .Address(addr[0]), .Write_data(wd[0]), .Read_data(rdata[0]),
        .rsp_valid(rv[0]), .stall(st[0]), .err(er[0])
    );

    data_mem_responder #(.ADDR_BITS(8), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .Mem_Read(rd[1]), .Mem_Write(wr[1]),
        .Address(addr[1]), .Write_data(wd[1]), .Read_data(rdata[1]),
        .rsp_valid(rv[1]), .stall(st[1]), .err(er[1])
    );

    data_mem_responder #(.ADDR_BITS(8), .DATA_W(32), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .reset(reset), .Mem_Read(rd[2]), .Mem_Write(wr[2]),
        .Address(addr[2]), .Write_data(wd[2]), .Read_data(rdata[2]),
        .rsp_valid(rv[2]), .stall(st[2]), .err(er[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // Drives one request on instance k starting at a falling edge (cycle 0)
    // and walks cycles 1..L+1. 'bad' counts cycles whose stall/rsp_valid
    // differ from: stall high in 0..L, rsp_valid high only in L+1. Read_data
    // and err are returned as seen in the DONE cycle.
    task automatic do_access(input int k, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic hold, output int bad,
                             output logic [31:0] rdata_o, output logic err_o);
        int l;
        l   = lat_of(k);
        bad = 0;
        @(negedge clk);
        rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
        #1;
        if (st[k] !== 1'b1 || rv[k] !== 1'b0) bad++;
        for (int c = 1; c <= l + 1; c++) begin
            @(negedge clk);
            if (st[k] !== (c <= l) || rv[k] !== (c == l + 1)) bad++;
        end
        rdata_o = rdata[k];
        err_o   = er[k];
        if (!hold) begin
            rd[k] = 1'b0;
            wr[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (st[k] !== 1'b0) begin
                errors++; $display("FAIL reset_stall[%0d]: got %b, expected 0", k, st[k]);
            end
            checks++;
            if (rv[k] !== 1'b0) begin
                errors++; $display("FAIL reset_rsp_valid[%0d]: got %b, expected 0", k, rv[k]);
            end
            checks++;
            if (rdata[k] !== 32'h0) begin
                errors++; $display("FAIL reset_read_data[%0d]: got %h, expected 0", k, rdata[k]);
            end
            checks++;
            if (er[k] !== 1'b0) begin
                errors++; $display("FAIL reset_err[%0d]: got %b, expected 0", k, er[k]);
            end
        end
        rd[0] = 1'b1;
        #1;
        checks++;
        if (st[0] !== 1'b1) begin
            errors++; $display("FAIL reset_stall_follows_req: got %b, expected 1", st[0]);
        end
        rd[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int          bad;
        logic [31:0] d;
        logic        e;
        do_access(0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL store_profile: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL store_keeps_read_data: got %h, expected 00000000", d);
        end
        do_access(0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL load_profile: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_data: got %h, expected deadbeef", d);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL load_err: got %b, expected 0", e);
        end
    endtask

    task automatic test_held_request();
        int          bad;
        int          extra;
        logic [31:0] d;
        logic        e;
        do_access(0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b1, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL held_first_profile: got %0d bad cycles, expected 0", bad);
        end
        // Request still high: the repeat must start in the cycle after DONE
        // with rsp_valid low there.
        do_access(0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL held_repeat_profile: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL held_repeat_data: got %h, expected deadbeef", d);
        end
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (rv[0] !== 1'b0 || st[0] !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL held_no_duplicate: got %0d active cycles, expected 0", extra);
        end
    endtask

    task automatic test_out_of_range();
        int          bad;
        logic [31:0] d;
        logic        e;
        do_access(0, 1'b0, 1'b1, 32'd0,   32'h11111111, 1'b0, bad, d, e);
        do_access(0, 1'b0, 1'b1, 32'd255, 32'hCAFEF00D, 1'b0, bad, d, e);
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("FAIL in_range_err: got %b, expected 0", e);
        end
        do_access(0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL oor_load_profile: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL oor_load_data: got %h, expected 00000000", d);
        end
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL oor_load_err: got %b, expected 1", e);
        end
        do_access(0, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 1'b0, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL oor_store_profile: got %0d bad cycles, expected 0", bad);
        end
        do_access(0, 1'b1, 1'b0, 32'd0, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (d !== 32'h11111111) begin
            errors++; $display("FAIL oor_store_dropped: got %h, expected 11111111", d);
        end
        do_access(0, 1'b1, 1'b0, 32'd255, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++; $display("FAIL top_word_data: got %h, expected cafef00d", d);
        end
    endtask

    task automatic test_both_strobes();
        int          bad;
        logic [31:0] d;
        logic        e;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (er[0] !== 1'b0) begin
            errors++; $display("FAIL err_cleared_by_reset: got %b, expected 0", er[0]);
        end
        do_access(0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL array_survives_reset: got %h, expected deadbeef", d);
        end
        do_access(0, 1'b1, 1'b1, 32'd3, 32'h55, 1'b0, bad, d, e);
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL both_profile: got %0d bad cycles, expected 0", bad);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL both_keeps_read_data: got %h, expected deadbeef", d);
        end
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL both_err: got %b, expected 1", e);
        end
        do_access(0, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (d !== 32'h55) begin
            errors++; $display("FAIL both_stored: got %h, expected 00000055", d);
        end
    endtask

    task automatic test_reset_in_busy();
        int          bad;
        int          pulses;
        logic [31:0] d;
        logic        e;
        do_access(0, 1'b0, 1'b1, 32'd7, 32'h77, 1'b0, bad, d, e);
        // Cycle 0: present the store.
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'd7; wd[0] = 32'h1234;
        // Cycle 1: first BUSY cycle, reset asserted.
        @(negedge clk);
        checks++;
        if (st[0] !== 1'b1) begin
            errors++; $display("FAIL rst_busy_stall_before: got %b, expected 1", st[0]);
        end
        reset = 1'b1;
        wr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (st[0] !== 1'b0) begin
            errors++; $display("FAIL rst_busy_stall_after: got %b, expected 0", st[0]);
        end
        reset  = 1'b0;
        pulses = (rv[0] === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (rv[0] !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL rst_busy_no_rsp: got %0d pulses, expected 0", pulses);
        end
        do_access(0, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, bad, d, e);
        checks++;
        if (d !== 32'h77) begin
            errors++; $display("FAIL rst_busy_store_discarded: got %h, expected 00000077", d);
        end
    endtask

    task automatic test_latency_sweep();
        int          bad;
        logic [31:0] d;
        logic        e;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] aa [3];
        logic [31:0] ab [3];
        va[1] = 32'h0000ABCD; vb[1] = 32'hFFFF0001; aa[1] = 32'd9;   ab[1] = 32'd10;
        va[2] = 32'h13579BDF; vb[2] = 32'h2468ACE0; aa[2] = 32'd200; ab[2] = 32'd0;
        for (int k = 1; k < 3; k++) begin
            do_access(k, 1'b0, 1'b1, aa[k], va[k], 1'b0, bad, d, e);
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL sweep_store_profile[L=%0d]: got %0d bad cycles, expected 0", lat_of(k), bad);
            end
            do_access(k, 1'b0, 1'b1, ab[k], vb[k], 1'b0, bad, d, e);
            do_access(k, 1'b1, 1'b0, aa[k], 32'h0, 1'b0, bad, d, e);
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL sweep_load_profile[L=%0d]: got %0d bad cycles, expected 0", lat_of(k), bad);
            end
            checks++;
            if (d !== va[k]) begin
                errors++; $display("FAIL sweep_load_a[L=%0d]: got %h, expected %h", lat_of(k), d, va[k]);
            end
            do_access(k, 1'b1, 1'b0, ab[k], 32'h0, 1'b0, bad, d, e);
            checks++;
            if (d !== vb[k]) begin
                errors++; $display("FAIL sweep_load_b[L=%0d]: got %h, expected %h", lat_of(k), d, vb[k]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0;
        end
        test_reset();
        test_store_load();
        test_held_request();
        test_out_of_range();
        test_both_strobes();
        test_reset_in_busy();
        test_latency_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
